// File: rtl/cuo_crossbar_row_sequencer.sv
// Row-serial crossbar driver: one shared DAC loads each row word, waits out memristor settling, then accumulates one ADC sample per row.
// Latency: start sampled at edge E -> result_valid from edge E + ROWS*(SETTLE_CYCLES+2); abort returns to IDLE on the next edge.
// Backpressure: the result is held in DONE until result_ready; start is ignored while busy, so no new operation is accepted until the result is taken.
module cuo_crossbar_row_sequencer #(
  parameter int PRECISION     = 12,
  parameter int ROWS          = 8,
  parameter int SETTLE_CYCLES = 20,
  parameter int ACC_W         = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ROWS*PRECISION-1:0] data_in,
  output logic                      busy,
  output logic [PRECISION-1:0]      dac_out,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] dac_row,
  output logic                      dac_we,
  input  logic [PRECISION-1:0]      adc_in,
  output logic [ACC_W-1:0]          result_out,
  output logic                      result_valid,
  input  logic                      result_ready
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // Reject parameter sets where the accumulator could wrap or the sequence is empty.
  generate
    if (ROWS < 1) begin : g_bad_rows
      $error("cuo_crossbar_row_sequencer: ROWS must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("cuo_crossbar_row_sequencer: SETTLE_CYCLES must be >= 1");
    end
    if (ACC_W < PRECISION + ROW_W) begin : g_bad_acc
      $error("cuo_crossbar_row_sequencer: ACC_W must be >= PRECISION + ROW_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READ   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [ROWS*PRECISION-1:0]   word_q, word_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic                        busy_q, busy_d;
  logic [PRECISION-1:0]        dac_out_q, dac_out_d;
  logic [ROW_W-1:0]            dac_row_q, dac_row_d;
  logic                        dac_we_q, dac_we_d;
  logic [ACC_W-1:0]            result_out_q, result_out_d;
  logic                        result_valid_q, result_valid_d;
  logic [ROW_W-1:0]            row_nxt;
  logic [ACC_W-1:0]            acc_sum;

  // Next-state and registered-output computation; DAC outputs are set on the edge that enters LOAD.
  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    row_d          = row_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    dac_out_d      = dac_out_q;
    dac_row_d      = dac_row_q;
    dac_we_d       = 1'b0;
    result_out_d   = result_out_q;
    result_valid_d = result_valid_q;
    row_nxt        = row_q + 1'b1;
    acc_sum        = acc_q + ACC_W'(adc_in);

    case (state_q)
      ST_IDLE: begin
        // abort outranks start, so a coincident pair leaves the sequencer idle
        if (start && !abort) begin
          word_d    = data_in;
          acc_d     = '0;
          row_d     = '0;
          cnt_d     = '0;
          dac_we_d  = 1'b1;
          dac_out_d = data_in[PRECISION-1:0];
          dac_row_d = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        acc_d = acc_sum;
        if (row_q == ROW_W'(ROWS - 1)) begin
          result_out_d   = acc_sum;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          row_d     = row_nxt;
          dac_we_d  = 1'b1;
          dac_out_d = word_q[int'(row_nxt) * PRECISION +: PRECISION];
          dac_row_d = row_nxt;
          state_d   = ST_LOAD;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Cancel an in-flight operation: nothing partial may reach the result port.
    if ((state_q == ST_LOAD) || (state_q == ST_SETTLE) || (state_q == ST_READ)) begin
      if (abort) begin
        state_d        = ST_IDLE;
        acc_d          = '0;
        row_d          = '0;
        cnt_d          = '0;
        dac_we_d       = 1'b0;
        dac_out_d      = dac_out_q;
        dac_row_d      = dac_row_q;
        result_out_d   = result_out_q;
        result_valid_d = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops everything to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      word_q         <= '0;
      row_q          <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      busy_q         <= 1'b0;
      dac_out_q      <= '0;
      dac_row_q      <= '0;
      dac_we_q       <= 1'b0;
      result_out_q   <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_q         <= word_d;
      row_q          <= row_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      busy_q         <= busy_d;
      dac_out_q      <= dac_out_d;
      dac_row_q      <= dac_row_d;
      dac_we_q       <= dac_we_d;
      result_out_q   <= result_out_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = busy_q;
  assign dac_out      = dac_out_q;
  assign dac_row      = dac_row_q;
  assign dac_we       = dac_we_q;
  assign result_out   = result_out_q;
  assign result_valid = result_valid_q;

endmodule
